// File: rtl/bus_combine_pipe.sv
// bus_combine_pipe: combines two operand buses under a 2-bit opcode and
// registers each result into a 2-entry FIFO with valid/ready handshakes on
// both sides. A completed-transaction counter tracks consumed results.
// Optional feature macro: BUS_COMBINE_SAT_EN (saturating ADD).
module bus_combine_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] txn_count
);

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] data;
    } entry_t;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    entry_t [1:0]     buf_q;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             push, pop;
    logic [WIDTH:0]   sum;
    entry_t           result;

    // Handshake flags come from registered occupancy only
    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = buf_q[rd_ptr_q].data;
    assign out_carry = buf_q[rd_ptr_q].carry;
    assign txn_count = cnt_q;

    assign sum = {1'b0, in_a} + {1'b0, in_b};

    // Result for the incoming operands; written to the buffer on push
    always_comb begin
        result = '0;
        case (in_op)
            OP_PASS: result.data = in_a;
            OP_ADD: begin
                result.carry = sum[WIDTH];
`ifdef BUS_COMBINE_SAT_EN
                result.data  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                result.data  = sum[WIDTH-1:0];
`endif
            end
            OP_AND:  result.data = in_a & in_b;
            OP_OR:   result.data = in_a | in_b;
            default: result = '0;
        endcase
    end

    // Next-state for pointers, occupancy and counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            cnt_d    = cnt_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Control state; async reset drops all buffered entries at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // Buffer storage; cleared on reset so the idle output reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (push) begin
            buf_q[wr_ptr_q] <= result;
        end
    end

endmodule

// File: tb/tb_bus_combine_pipe.sv
module tb_bus_combine_pipe;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_a, in_b;
    logic [1:0]       in_op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] txn_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_combine_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_carry(out_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .txn_count(txn_count)
    );

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00; out_ready = 1'b0;
        #22;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_low_out_valid got %b exp 0", out_valid); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        tests++; if (txn_count !== 8'd0) begin fails++; $display("FAIL rst_txn got %0d exp 0", txn_count); end
        tests++; if (out_data !== 4'd0) begin fails++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        tests++; if (out_carry !== 1'b0) begin fails++; $display("FAIL rst_out_carry got %b exp 0", out_carry); end
    endtask

    task automatic test_opcodes();
        logic [3:0] exp_d [4];
        exp_d[0] = 4'b0011; exp_d[1] = 4'b0100; exp_d[2] = 4'b0001; exp_d[3] = 4'b0011;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_a = 4'b0011; in_b = 4'b0001; in_op = 2'(i); in_valid = 1'b1;
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
                fails++; $display("FAIL op%0d_data got v=%b d=%b exp v=1 d=%b", i, out_valid, out_data, exp_d[i]); end
            tests++; if (out_carry !== 1'b0) begin fails++; $display("FAIL op%0d_carry got %b exp 0", i, out_carry); end
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (txn_count !== 8'd4) begin fails++; $display("FAIL op_txn got %0d exp 4", txn_count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL op_drain_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_d;
`ifdef BUS_COMBINE_SAT_EN
        exp_d = 4'b1111;
`else
        exp_d = 4'b0001;
`endif
        @(negedge clk);
        in_a = 4'b1111; in_b = 4'b0010; in_op = 2'b01; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); in_valid = 1'b0;
        tests++; if (out_data !== exp_d) begin fails++; $display("FAIL ovf_data got %b exp %b", out_data, exp_d); end
        tests++; if (out_carry !== 1'b1) begin fails++; $display("FAIL ovf_carry got %b exp 1", out_carry); end
        @(posedge clk); #1;
        tests++; if (out_data !== exp_d || out_carry !== 1'b1 || out_valid !== 1'b1) begin
            fails++; $display("FAIL ovf_stall_hold got d=%b c=%b v=%b exp d=%b c=1 v=1", out_data, out_carry, out_valid, exp_d); end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (txn_count !== 8'd5 || out_valid !== 1'b0) begin
            fails++; $display("FAIL ovf_pop got txn=%0d v=%b exp txn=5 v=0", txn_count, out_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0; in_op = 2'b00; in_b = 4'd0; in_a = 4'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
        @(negedge clk); in_a = 4'd2;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready2 got %b exp 0", in_ready); end
        @(negedge clk); in_a = 4'd3;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b0 || out_data !== 4'd1) begin
            fails++; $display("FAIL bp_held got rdy=%b d=%h exp rdy=0 d=1", in_ready, out_data); end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (out_data !== 4'd2 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            fails++; $display("FAIL bp_pop1 got d=%h rdy=%b v=%b exp d=2 rdy=1 v=1", out_data, in_ready, out_valid); end
        @(posedge clk); #1;
        tests++; if (out_data !== 4'd3 || out_valid !== 1'b1) begin
            fails++; $display("FAIL bp_third got d=%h v=%b exp d=3 v=1", out_data, out_valid); end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0 || txn_count !== 8'd8) begin
            fails++; $display("FAIL bp_drain got v=%b txn=%0d exp v=0 txn=8", out_valid, txn_count); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b0; in_op = 2'b00; in_b = 4'd0; in_a = 4'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_a = 4'(i + 1);
            @(posedge clk); #1;
            tests++; if (out_data !== 4'(i + 1) || out_valid !== 1'b1 || in_ready !== 1'b1) begin
                fails++; $display("FAIL b2b_%0d got d=%h v=%b rdy=%b exp d=%h v=1 rdy=1", i, out_data, out_valid, in_ready, 4'(i + 1)); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests++; if (txn_count !== 8'd16) begin fails++; $display("FAIL b2b_txn got %0d exp 16", txn_count); end
        @(posedge clk); #1;
        tests++; if (txn_count !== 8'd17 || out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_drain got txn=%0d v=%b exp 17 0", txn_count, out_valid); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0; in_op = 2'b00; in_a = 4'd9; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); in_a = 4'd10;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ar_full got rdy=%b exp 0", in_ready); end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || txn_count !== 8'd0) begin
            fails++; $display("FAIL ar_immediate got v=%b txn=%0d exp 0 0", out_valid, txn_count); end
        @(negedge clk); rst_n = 1'b1;
        in_a = 4'b0101; in_b = 4'b0011; in_op = 2'b01; in_valid = 1'b1;
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b1 || out_data !== 4'b1000 || out_carry !== 1'b0) begin
            fails++; $display("FAIL ar_post_push got v=%b d=%b c=%b exp 1 1000 0", out_valid, out_data, out_carry); end
        @(negedge clk); in_op = 2'b10; out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (out_data !== 4'b0001 || txn_count !== 8'd1) begin
            fails++; $display("FAIL ar_and got d=%b txn=%0d exp 0001 1", out_data, txn_count); end
        @(negedge clk); in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_opcodes();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_combine_pipe.md
Name: bus_combine_pipe

Overview:
- Parametrised, pipelined successor to the team's 4-bit two-bus combinational block.
- Combines two WIDTH-bit operand buses under a 2-bit opcode.
- Registers each result into a 2-entry output buffer with valid/ready handshakes on both sides.
- Sits between a bus source and a downstream consumer; tolerates consumer stalls without losing data.

Parameters:
- WIDTH, 4, operand and result width in bits (>=1).
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  2  opcode: 00 pass A, 01 A+B, 10 A AND B, 11 A OR B.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept a transaction this cycle.
- out_data  output  WIDTH  result at head of buffer.
- out_carry  output  1  carry-out of the ADD for the head entry; 0 for other opcodes.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- txn_count  output  CNT_W  number of results consumed since reset.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values: all outputs and internal state cleared. in_ready=1 once rst_n is high; out_valid=0, out_data=0, out_carry=0, txn_count=0, occupancy=0.
- Accept: push when in_valid && in_ready at a rising edge. A and B are sampled and the result is computed combinationally, then written into the buffer at that edge.
- Consume: pop when out_valid && out_ready at a rising edge.
- Latency: a result pushed at edge N is visible on out_data/out_valid after edge N, provided the buffer was empty. No combinational path from in_* to out_*.
- Buffer: 2 entries, FIFO order, occupancy register 0..2.
  - in_ready = (occupancy != 2), decoded from registered state only. No combinational dependence on out_ready.
  - out_valid = (occupancy != 0).
- Simultaneous push and pop:
  - occupancy 1: unchanged; the head advances to the new entry on the next cycle.
  - occupancy 2: push is impossible (in_ready=0), so only the pop occurs and occupancy drops to 1. in_ready rises the following cycle.
  - occupancy 0: only a push can occur, since out_valid=0.
- Arithmetic:
  - ADD is a WIDTH+1-bit sum. The low WIDTH bits go to the data entry and bit WIDTH to the carry entry.
  - AND, OR and pass store carry=0.
  - No sign interpretation.
- Stability: while out_valid=1 and out_ready=0, out_data and out_carry hold stable.
- Transaction counter: txn_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Invalid-input handling: in_valid=1 while in_ready=0 is ignored. Operands are not captured, and the source must hold them.
- Reset mid-operation: rst_n low discards all buffered entries immediately (asynchronous). out_valid falls without waiting for a clock edge.

Optional Feature:
- Macro: BUS_COMBINE_SAT_EN.
- Defined: ADD saturates. If the carry is 1, the stored data is all-ones (2^WIDTH-1); out_carry is still reported as 1.
- Undefined: ADD wraps modulo 2^WIDTH. Behaviour is otherwise identical.

Test Plan:
- Reset/idle: hold rst_n=0, then release with in_valid=0 -> in_ready=1, out_valid=0, txn_count=0, out_data=0.
- Opcode sweep (WIDTH=4, out_ready=1): A=0011, B=0001 for op 00,01,10,11 -> out_data 0011, 0100, 0001, 0011, each one cycle after acceptance; out_carry=0 throughout; txn_count=4.
- Overflow: A=1111, B=0010, op=01 -> carry=1. Data 0001 without the macro, 1111 with BUS_COMBINE_SAT_EN.
- Backpressure: out_ready=0, push A=0001, 0010, 0011 op=00 on consecutive cycles -> in_ready falls after the second push and the third is held. Raise out_ready -> outputs 0001, 0010, 0011 in order; the third is accepted the cycle after in_ready returns.
- Simultaneous push/pop at occupancy 1 for 8 cycles with both valid and ready high -> one result per cycle, occupancy constant, txn_count +8.
- Async reset mid-stream: assert rst_n=0 between edges with occupancy 2 -> out_valid=0 and txn_count=0 immediately. The next post-reset push reaches the output with 1-cycle latency.
